// File: rtl/anfsqrt_ctrl_pkg.sv
// Shared definitions for the ANF integer square-root unit.
// Holds widths, FSM encoding, the iteration record and the bit-square helper.
package anfsqrt_ctrl_pkg;

  localparam int ANFSQRT_W      = 32;
  localparam int ANFSQRT_ROOT_W = 16;
  localparam int ANFSQRT_REM_W  = 17;
  localparam int ANFSQRT_STEPS  = 16;

  localparam logic [ANFSQRT_W-1:0] ATT_INIT = 32'h0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One iteration's working set: trial bit, remaining radicand, partial root.
  typedef struct packed {
    logic [ANFSQRT_W-1:0] att;
    logic [ANFSQRT_W-1:0] eps;
    logic [ANFSQRT_W-1:0] res;
  } iter_t;

  // Square of a one-hot root bit: bit i moves to bit 2i, so this is pure wiring.
  function automatic logic [ANFSQRT_W-1:0] bit_square(input logic [ANFSQRT_ROOT_W-1:0] b);
    logic [ANFSQRT_W-1:0] sq;
    sq = '0;
    for (int i = 0; i < ANFSQRT_ROOT_W; i++) begin
      sq[2*i] = b[i];
    end
    return sq;
  endfunction

endpackage

// File: rtl/anfsqrt_sqrtiu.sv
// One combinational iteration of the digit-by-digit square root.
// Resolves a single root bit: subtract (res + bit^2) from eps when it fits.
module anfsqrt_sqrtiu
  import anfsqrt_ctrl_pkg::*;
(
  input  iter_t cur,
  output iter_t nxt
);

  logic [ANFSQRT_W-1:0] att_sh;
  logic [ANFSQRT_W-1:0] one;
  logic [ANFSQRT_W-1:0] trial;

  // att walks one bit lower per step; rotating keeps every bit in use.
  assign att_sh = {cur.att[0], cur.att[ANFSQRT_W-1:1]};
  assign one    = bit_square(att_sh[ANFSQRT_ROOT_W-1:0]);
  assign trial  = cur.res + one;

  always_comb begin
    nxt.att = att_sh;
    if (cur.eps >= trial) begin
      nxt.eps = cur.eps - trial;
      nxt.res = (cur.res >> 1) + one;
    end else begin
      nxt.eps = cur.eps;
      nxt.res = cur.res >> 1;
    end
  end

endmodule

// File: rtl/anfsqrt_ctrl.sv
// Dispatcher for the ANF square root: accepts a radicand, steps IPC chained
// iteration units per cycle for 16/IPC cycles, then holds root and remainder.
module anfsqrt_ctrl
  import anfsqrt_ctrl_pkg::*;
#(
  parameter int IPC = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ANFSQRT_W-1:0]      in_n,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ANFSQRT_ROOT_W-1:0] out_root,
  output logic [ANFSQRT_REM_W-1:0]  out_rem
);

  localparam int CYCLES = ANFSQRT_STEPS / IPC;
  localparam int CNT_W  = $clog2(CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  if (!(IPC == 1 || IPC == 2 || IPC == 4 || IPC == 8 || IPC == 16)) begin : g_bad_ipc
    $error("anfsqrt_ctrl: IPC must be 1, 2, 4, 8 or 16");
  end

  state_e           state_q, state_d;
  iter_t            cur_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load, step;

  iter_t [IPC:0] chain;

  assign chain[0] = cur_q;

  for (genvar k = 0; k < IPC; k++) begin : g_iu
    anfsqrt_sqrtiu u_iu (
      .cur (chain[k]),
      .nxt (chain[k+1])
    );
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_root = out_valid ? cur_q.res[ANFSQRT_ROOT_W-1:0] : '0;
  assign out_rem  = out_valid ? cur_q.eps[ANFSQRT_REM_W-1:0]  : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cur_q <= '{att: ATT_INIT, eps: in_n, res: '0};
        cnt_q <= CNT_INIT;
      end else if (step) begin
        cur_q <= chain[IPC];
        cnt_q <= cnt_q - CNT_LAST;
      end
    end
  end

endmodule

// File: tb/tb_anfsqrt_ctrl.sv
// Self-checking bench for anfsqrt_ctrl: directed vectors on an IPC=1 instance
// plus randomized radicands on one instance per legal IPC value.
module tb_anfsqrt_ctrl;

  localparam int N_RND = 1500;

  logic clk;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Floor square root by binary search over the root range.
  function automatic longint unsigned ref_root(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // ---------------- main IPC=1 instance ----------------
  logic        m_rst_n, m_iv, m_ir, m_ov, m_ordy;
  logic [31:0] m_n;
  logic [15:0] m_root;
  logic [16:0] m_rem;

  anfsqrt_ctrl #(.IPC(1)) u_main (
    .clk       (clk),
    .rst_n     (m_rst_n),
    .in_valid  (m_iv),
    .in_ready  (m_ir),
    .in_n      (m_n),
    .out_valid (m_ov),
    .out_ready (m_ordy),
    .out_root  (m_root),
    .out_rem   (m_rem)
  );

  task automatic run_op(input logic [31:0] x, output logic [15:0] r,
                        output logic [16:0] m, output int lat);
    @(negedge clk);
    m_iv = 1'b1;
    m_n  = x;
    m_ordy = 1'b0;
    check("idle_in_ready", 64'(m_ir), 64'd1);
    @(posedge clk);
    @(negedge clk);
    m_iv = 1'b0;
    lat  = 0;
    while (!m_ov && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    r = m_root;
    m = m_rem;
    m_ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ordy = 1'b0;
  endtask

  typedef struct {
    logic [31:0] n;
    logic [15:0] root;
    logic [16:0] rem;
  } vec_t;

  vec_t vecs[11];

  // ---------------- random instances, one per IPC ----------------
  logic r_rst_n;

  for (genvar g = 0; g < 5; g++) begin : g_rnd
    localparam int P   = 1 << g;
    localparam int LAT = 16 / P;
    logic        iv, ir, ov, ordy, done;
    logic [31:0] n;
    logic [15:0] rt;
    logic [16:0] rm;

    anfsqrt_ctrl #(.IPC(P)) u_dut (
      .clk       (clk),
      .rst_n     (r_rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_n      (n),
      .out_valid (ov),
      .out_ready (ordy),
      .out_root  (rt),
      .out_rem   (rm)
    );

    initial begin
      logic [31:0]     x;
      longint unsigned r, rr;
      logic [15:0]     er;
      logic [16:0]     em;
      int              lat, hold;
      iv = 1'b0; ordy = 1'b0; n = '0; done = 1'b0;
      @(posedge r_rst_n);
      for (int i = 0; i < N_RND; i++) begin
        case (i)
          0: x = 32'hFFFF_FFFF;
          1: x = 32'd0;
          default: begin
            case ($urandom_range(0, 2))
              0: x = 32'($urandom_range(0, 1000));
              1: begin
                rr = longint'($urandom_range(0, 65535));
                x  = 32'(rr * rr + longint'($urandom_range(0, 32'(2 * rr))));
              end
              default: x = $urandom;
            endcase
          end
        endcase
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        check($sformatf("rnd_in_ready_ipc%0d", P), 64'(ir), 64'd1);
        iv = 1'b1;
        n  = x;
        @(posedge clk);
        @(negedge clk);
        iv  = 1'b0;
        n   = $urandom;
        lat = 0;
        while (!ov && lat < 64) begin
          @(negedge clk);
          lat++;
        end
        r  = ref_root(longint'(x));
        er = 16'(r);
        em = 17'(longint'(x) - r * r);
        check($sformatf("rnd_lat_ipc%0d", P), 64'(lat), 64'(LAT));
        check($sformatf("rnd_root_ipc%0d n=%0h", P, x), 64'(rt), 64'(er));
        check($sformatf("rnd_rem_ipc%0d n=%0h", P, x), 64'(rm), 64'(em));
        hold = $urandom_range(0, 3);
        repeat (hold) begin
          @(negedge clk);
          check($sformatf("rnd_hold_ipc%0d", P), 64'({ov, rt, rm}), 64'({1'b1, er, em}));
        end
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy = 1'b0;
        check($sformatf("rnd_released_ipc%0d", P), 64'(ov), 64'd0);
      end
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] r;
    logic [16:0] m;
    int          lat, k, t1, t2, waited;
    logic        seen;

    vecs[0]  = '{32'd0,          16'd0,     17'd0};
    vecs[1]  = '{32'd1,          16'd1,     17'd0};
    vecs[2]  = '{32'd2,          16'd1,     17'd1};
    vecs[3]  = '{32'd3,          16'd1,     17'd2};
    vecs[4]  = '{32'd4,          16'd2,     17'd0};
    vecs[5]  = '{32'd99,         16'd9,     17'd18};
    vecs[6]  = '{32'd1_000_000,  16'd1000,  17'd0};
    vecs[7]  = '{32'hFFFF_FFFF,  16'hFFFF,  17'h1FFFE};
    vecs[8]  = '{32'd12345,      16'd111,   17'd24};
    vecs[9]  = '{32'hFFFE_0001,  16'hFFFF,  17'd0};
    vecs[10] = '{32'hFFFE_0000,  16'hFFFE,  17'h1FFFC};

    m_rst_n = 1'b0; r_rst_n = 1'b0;
    m_iv = 1'b0; m_ordy = 1'b0; m_n = '0;
    #2;
    check("reset_out_valid", 64'(m_ov), 64'd0);
    check("reset_out_root", 64'(m_root), 64'd0);
    check("reset_out_rem", 64'(m_rem), 64'd0);
    repeat (2) @(negedge clk);
    m_rst_n = 1'b1;
    r_rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 64'(m_ir), 64'd1);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].n, r, m, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd16);
      check($sformatf("vec%0d_root", i), 64'(r), 64'(vecs[i].root));
      check($sformatf("vec%0d_rem", i), 64'(m), 64'(vecs[i].rem));
    end

    // Back-to-back: 99 then 1_000_000 with out_ready held high.
    @(negedge clk);
    m_ordy = 1'b1; m_iv = 1'b1; m_n = 32'd99;
    @(posedge clk);
    @(negedge clk);
    m_n = 32'd1_000_000;
    k = 0;
    while (!m_ov && k < 64) begin
      @(negedge clk);
      k++;
    end
    t1 = cyc;
    check("b2b_first_lat", 64'(k), 64'd16);
    check("b2b_first_root", 64'(m_root), 64'd9);
    check("b2b_first_rem", 64'(m_rem), 64'd18);
    check("b2b_in_ready_done", 64'(m_ir), 64'd1);
    @(posedge clk);
    @(negedge clk);
    m_iv = 1'b0;
    check("b2b_no_bubble", 64'(m_ov), 64'd0);
    k = 0;
    while (!m_ov && k < 64) begin
      @(negedge clk);
      k++;
    end
    t2 = cyc;
    check("b2b_spacing", 64'(t2 - t1), 64'd17);
    check("b2b_second_root", 64'(m_root), 64'd1000);
    check("b2b_second_rem", 64'(m_rem), 64'd0);
    @(posedge clk);
    @(negedge clk);
    m_ordy = 1'b0;

    // Back-pressure: hold the result of n=1 for 10 cycles.
    @(negedge clk);
    m_iv = 1'b1; m_n = 32'd1;
    @(posedge clk);
    @(negedge clk);
    m_iv = 1'b0;
    k = 0;
    while (!m_ov && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("bp_lat", 64'(k), 64'd16);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i), 64'({m_ov, m_root, m_rem, m_ir}),
            64'({1'b1, 16'd1, 17'd0, 1'b0}));
      @(negedge clk);
    end
    m_ordy = 1'b1;
    #1;
    check("bp_in_ready_follows", 64'(m_ir), 64'd1);
    @(posedge clk);
    @(negedge clk);
    m_ordy = 1'b0;
    check("bp_released", 64'(m_ov), 64'd0);

    // Reset pulse during RUN cycle 7 of n=12345.
    @(negedge clk);
    m_iv = 1'b1; m_n = 32'd12345;
    @(posedge clk);
    @(negedge clk);
    m_iv = 1'b0;
    repeat (6) @(negedge clk);
    m_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(m_ov), 64'd0);
    check("midrst_out_root", 64'(m_root), 64'd0);
    @(negedge clk);
    m_rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_ov) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    run_op(32'd12345, r, m, lat);
    check("midrst_next_lat", 64'(lat), 64'd16);
    check("midrst_next_root", 64'(r), 64'd111);
    check("midrst_next_rem", 64'(m), 64'd24);

    waited = 0;
    while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done && g_rnd[4].done)
           && waited < 80000) begin
      @(posedge clk);
      waited++;
    end
    check("rnd_all_done",
          64'({g_rnd[0].done, g_rnd[1].done, g_rnd[2].done, g_rnd[3].done, g_rnd[4].done}),
          64'(5'b11111));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
